// File: rtl/histogram_ctrl_pkg.sv
// Shared types and defaults for the histogram BRAM controller.
package histogram_ctrl_pkg;

   localparam int unsigned ADDR_W_DEF = 10;
   localparam int unsigned DATA_W_DEF = 16;
   localparam logic [DATA_W_DEF-1:0] COUNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DRAIN,
      ST_CLEAR
   } state_t;

endpackage

// File: rtl/histogram_rmw_pipe.sv
// Two-stage increment pipeline: S1 issues the port-A read, S2 does the saturating
// add and drives port B, forwarding the previous write when the bins collide.
module histogram_rmw_pipe
   import histogram_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_accept,
   input  logic [ADDR_W-1:0] i_bin,
   input  logic [DATA_W-1:0] i_memDoutA,
   input  logic              i_clearWe,
   input  logic [ADDR_W-1:0] i_clearAddr,
   output logic              o_s2Valid,
   output logic              o_satHit,
   output logic              o_weB,
   output logic [ADDR_W-1:0] o_addrB,
   output logic [DATA_W-1:0] o_dinB,
   output logic              o_wbValid,
   output logic [ADDR_W-1:0] o_wbAddr,
   output logic [DATA_W-1:0] o_wbData
);

   localparam logic [DATA_W-1:0] W_MAX = '1;

   logic              r_s2Valid;
   logic [ADDR_W-1:0] r_s2Bin;
   logic              r_wbValid;
   logic [ADDR_W-1:0] r_wbAddr;
   logic [DATA_W-1:0] r_wbData;

   logic              w_fwd;
   logic [DATA_W-1:0] w_old;
   logic [DATA_W-1:0] w_new;
   logic              w_weB;
   logic [ADDR_W-1:0] w_addrB;
   logic [DATA_W-1:0] w_dinB;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s2Valid <= 1'b0;
         r_s2Bin   <= '0;
         r_wbValid <= 1'b0;
         r_wbAddr  <= '0;
         r_wbData  <= '0;
      end else begin
         r_s2Valid <= i_accept;
         r_s2Bin   <= i_bin;
         r_wbValid <= w_weB;
         r_wbAddr  <= w_addrB;
         r_wbData  <= w_dinB;
      end
   end

   // BRAM reads return pre-write data when a port-B write lands on the same edge.
   always_comb begin
      w_fwd   = r_wbValid && (r_wbAddr == r_s2Bin);
      w_old   = w_fwd ? r_wbData : i_memDoutA;
      w_new   = (w_old == W_MAX) ? W_MAX : w_old + 1'b1;
      w_weB   = 1'b0;
      w_addrB = '0;
      w_dinB  = '0;
      if (i_clearWe) begin
         w_weB   = 1'b1;
         w_addrB = i_clearAddr;
      end else if (r_s2Valid) begin
         w_weB   = 1'b1;
         w_addrB = r_s2Bin;
         w_dinB  = w_new;
      end
   end

   assign o_s2Valid = r_s2Valid;
   assign o_satHit  = r_s2Valid && (w_old == W_MAX);
   assign o_weB     = w_weB;
   assign o_addrB   = w_addrB;
   assign o_dinB    = w_dinB;
   assign o_wbValid = r_wbValid;
   assign o_wbAddr  = r_wbAddr;
   assign o_wbData  = r_wbData;

endmodule

// File: rtl/histogram_bin_controller.sv
// Histogram BRAM sequencer: event RMW pipe, starvation-bounded host reads on port A,
// and a drain-then-sweep clear of every bin.
module histogram_bin_controller
   import histogram_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W       = ADDR_W_DEF,
   parameter int unsigned DATA_W       = DATA_W_DEF,
   parameter int unsigned STARVE_LIMIT = 8,
   parameter bit          CLEAR_ON_RST = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              eventValid,
   input  logic [ADDR_W-1:0] eventBin,
   output logic              eventReady,
   input  logic              hostReadReq,
   input  logic [ADDR_W-1:0] hostReadAddr,
   output logic              hostReadBusy,
   output logic              hostReadValid,
   output logic [DATA_W-1:0] hostReadData,
   input  logic              clearStart,
   output logic              clearBusy,
   output logic              overflowSeen,
   output logic [31:0]       eventCount,
   output logic [ADDR_W-1:0] memAddrA,
   input  logic [DATA_W-1:0] memDoutA,
   output logic              memWeB,
   output logic [ADDR_W-1:0] memAddrB,
   output logic [DATA_W-1:0] memDinB
);

   localparam int unsigned SW = $clog2(STARVE_LIMIT + 2);

   state_t            r_state;
   logic [SW-1:0]     r_starve;
   logic              r_hostPend;
   logic              r_hostRd;
   logic [ADDR_W-1:0] r_hostAddr;
   logic              r_hostValid;
   logic [DATA_W-1:0] r_hostData;
   logic              r_ovf;
   logic [31:0]       r_evCnt;
   logic [ADDR_W-1:0] r_clrAddr;

   logic              w_hostGrant;
   logic              w_accept;
   logic              w_clearWe;
   logic              w_s2Valid;
   logic              w_satHit;
   logic              w_wbValid;
   logic [ADDR_W-1:0] w_wbAddr;
   logic [DATA_W-1:0] w_wbData;
   logic [DATA_W-1:0] w_hostRdData;

   // Host loses port A to a live event until it has been passed over STARVE_LIMIT times.
   assign w_hostGrant = (r_state == ST_RUN) && r_hostPend &&
                        (!eventValid || (r_starve == SW'(STARVE_LIMIT)));
   assign eventReady  = (r_state == ST_RUN) && !w_hostGrant && !reset;
   assign w_accept    = eventValid && eventReady;
   assign w_clearWe   = (r_state == ST_CLEAR) && !reset;
   assign memAddrA    = w_hostGrant ? r_hostAddr : (w_accept ? eventBin : '0);

   histogram_rmw_pipe #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_pipe (
      .clk         (clk),
      .reset       (reset),
      .i_accept    (w_accept),
      .i_bin       (eventBin),
      .i_memDoutA  (memDoutA),
      .i_clearWe   (w_clearWe),
      .i_clearAddr (r_clrAddr),
      .o_s2Valid   (w_s2Valid),
      .o_satHit    (w_satHit),
      .o_weB       (memWeB),
      .o_addrB     (memAddrB),
      .o_dinB      (memDinB),
      .o_wbValid   (w_wbValid),
      .o_wbAddr    (w_wbAddr),
      .o_wbData    (w_wbData)
   );

   always_comb begin
      w_hostRdData = memDoutA;
      if (memWeB && (memAddrB == r_hostAddr))
         w_hostRdData = memDinB;
      else if (w_wbValid && (w_wbAddr == r_hostAddr))
         w_hostRdData = w_wbData;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= CLEAR_ON_RST ? ST_CLEAR : ST_RUN;
         r_starve    <= '0;
         r_hostPend  <= 1'b0;
         r_hostRd    <= 1'b0;
         r_hostAddr  <= '0;
         r_hostValid <= 1'b0;
         r_hostData  <= '0;
         r_ovf       <= 1'b0;
         r_evCnt     <= '0;
         r_clrAddr   <= '0;
      end else begin
         if (w_accept)
            r_evCnt <= r_evCnt + 32'd1;
         if (w_satHit)
            r_ovf <= 1'b1;

         case (r_state)
            ST_RUN:
               if (clearStart)
                  r_state <= ST_DRAIN;
            ST_DRAIN:
               if (!w_s2Valid) begin
                  r_state   <= ST_CLEAR;
                  r_clrAddr <= '0;
                  r_evCnt   <= '0;
                  r_ovf     <= 1'b0;
               end
            ST_CLEAR: begin
               r_clrAddr <= r_clrAddr + 1'b1;
               if (r_clrAddr == '1)
                  r_state <= ST_RUN;
            end
            default: r_state <= ST_RUN;
         endcase

         r_hostRd    <= w_hostGrant;
         r_hostValid <= r_hostRd;
         if (r_hostRd)
            r_hostData <= w_hostRdData;

         if (w_hostGrant) begin
            r_hostPend <= 1'b0;
            r_starve   <= '0;
         end else begin
            if (hostReadReq && !hostReadBusy) begin
               r_hostPend <= 1'b1;
               r_hostAddr <= hostReadAddr;
            end
            if ((r_state == ST_RUN) && r_hostPend)
               r_starve <= r_starve + 1'b1;
         end
      end
   end

   assign hostReadBusy  = r_hostPend || r_hostRd;
   assign hostReadValid = r_hostValid;
   assign hostReadData  = r_hostData;
   assign clearBusy     = (r_state != ST_RUN) && !reset;
   assign overflowSeen  = r_ovf;
   assign eventCount    = r_evCnt;

endmodule

// File: tb/tb_histogram_bin_controller.sv
// Bench for histogram_bin_controller: BRAM model, bin-count reference model and
// directed scenarios with literal expectations.
module tb_histogram_bin_controller;
   import histogram_ctrl_pkg::*;

   localparam int AW = 10;
   localparam int DW = 16;
   localparam int SL = 8;
   localparam int NB = 1 << AW;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          eventValid = 1'b0;
   logic [AW-1:0] eventBin = '0;
   logic          eventReady;
   logic          hostReadReq = 1'b0;
   logic [AW-1:0] hostReadAddr = '0;
   logic          hostReadBusy;
   logic          hostReadValid;
   logic [DW-1:0] hostReadData;
   logic          clearStart = 1'b0;
   logic          clearBusy;
   logic          overflowSeen;
   logic [31:0]   eventCount;
   logic [AW-1:0] memAddrA;
   logic [DW-1:0] memDoutA = '0;
   logic          memWeB;
   logic [AW-1:0] memAddrB;
   logic [DW-1:0] memDinB;

   logic          pre_we = 1'b0;
   logic [AW-1:0] pre_addr = '0;
   logic [DW-1:0] pre_data = '0;

   logic [DW-1:0] mem [NB];
   logic [DW-1:0] ref_bins [NB];
   logic [31:0]   m_count = '0;
   logic          m_ovf = 1'b0;
   logic [AW-1:0] m_rdAddr = '0;
   int            m_rdIssued = 0;
   int            rd_done = 0;

   int n_checks = 0;
   int n_fails = 0;

   histogram_bin_controller #(
      .ADDR_W       (AW),
      .DATA_W       (DW),
      .STARVE_LIMIT (SL),
      .CLEAR_ON_RST (1'b1)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .eventValid    (eventValid),
      .eventBin      (eventBin),
      .eventReady    (eventReady),
      .hostReadReq   (hostReadReq),
      .hostReadAddr  (hostReadAddr),
      .hostReadBusy  (hostReadBusy),
      .hostReadValid (hostReadValid),
      .hostReadData  (hostReadData),
      .clearStart    (clearStart),
      .clearBusy     (clearBusy),
      .overflowSeen  (overflowSeen),
      .eventCount    (eventCount),
      .memAddrA      (memAddrA),
      .memDoutA      (memDoutA),
      .memWeB        (memWeB),
      .memAddrB      (memAddrB),
      .memDinB       (memDinB)
   );

   always #5 clk = ~clk;

   // Dual-port BRAM: read returns the contents before a same-edge write.
   always @(posedge clk) begin
      memDoutA <= mem[memAddrA];
      if (pre_we)
         mem[pre_addr] <= pre_data;
      else if (memWeB)
         mem[memAddrB] <= memDinB;
   end

   // Reference: what every bin should hold given accepted events, preloads and clears.
   always @(posedge clk) begin
      if (reset) begin
         m_count = '0;
         m_ovf   = 1'b0;
         for (int i = 0; i < NB; i++) ref_bins[i] = '0;
      end else begin
         if (eventValid && eventReady) begin
            m_count = m_count + 1;
            if (ref_bins[eventBin] == COUNT_MAX) m_ovf = 1'b1;
            else ref_bins[eventBin] = ref_bins[eventBin] + 1'b1;
         end
         if (hostReadReq) begin
            m_rdAddr   = hostReadAddr;
            m_rdIssued = m_rdIssued + 1;
         end
         if (pre_we) ref_bins[pre_addr] = pre_data;
         if (clearStart) begin
            for (int i = 0; i < NB; i++) ref_bins[i] = '0;
            m_count = '0;
            m_ovf   = 1'b0;
         end
      end
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (!clearBusy) check("evcount", 64'(eventCount), 64'(m_count));
            else check("ready_in_clear", 64'(eventReady), 64'd0);
            if (hostReadValid) begin
               check("rd_expected", 64'(m_rdIssued > rd_done), 64'd1);
               check("rd_data", 64'(hostReadData), 64'(ref_bins[m_rdAddr]));
               rd_done++;
            end
         end
      end
   endtask

   task automatic host_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                            output int lat, output int low);
      logic got;
      got = 1'b0;
      d = '0;
      lat = 0;
      low = 0;
      hostReadReq  = 1'b1;
      hostReadAddr = a;
      @(negedge clk);
      if (!eventReady) low++;
      tick();
      hostReadReq = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         lat++;
         if (!eventReady) low++;
         if (hostReadValid) begin
            got = 1'b1;
            d = hostReadData;
         end
      end
      check("hostread_arrived", 64'(got), 64'd1);
      tick();
   endtask

   task automatic wait_clear(input logic pulse_mid, output int n);
      logic seen;
      logic done;
      seen = 1'b0;
      done = 1'b0;
      n = 0;
      for (int i = 0; i < 1300 && !done; i++) begin
         @(negedge clk);
         clearStart = 1'b0;
         if (clearBusy) seen = 1'b1;
         if (clearBusy && memWeB && memDinB == '0 && memAddrB == AW'(n)) n++;
         if (pulse_mid && n == 500) clearStart = 1'b1;
         if (seen && !clearBusy) done = 1'b1;
      end
      clearStart = 1'b0;
      check("clear_finished", 64'(done), 64'd1);
      tick();
   endtask

   task automatic check_mem_zero(input string nm);
      int nz;
      nz = 0;
      for (int i = 0; i < NB; i++) if (mem[i] != '0) nz++;
      check(nm, 64'(nz), 64'd0);
   endtask

   task automatic send_events(input logic [AW-1:0] b, input int n);
      eventValid = 1'b1;
      eventBin   = b;
      for (int i = 0; i < n; i++) tick();
      eventValid = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] d;
      int lat;
      int low;
      int n;
      int pre_bins [4];
      logic reached;
      pre_bins = '{0, 5, 300, 1023};

      fork
         monitor();
      join_none

      // Seed non-zero garbage under reset so the power-up sweep has something to erase.
      for (int k = 0; k < 4; k++) begin
         pre_we   = 1'b1;
         pre_addr = AW'(pre_bins[k]);
         pre_data = 16'h1234;
         tick();
      end
      pre_we = 1'b0;
      @(negedge clk);
      check("rst_eventReady", 64'(eventReady), 64'd0);
      check("rst_clearBusy", 64'(clearBusy), 64'd0);
      check("rst_memWeB", 64'(memWeB), 64'd0);
      check("rst_eventCount", 64'(eventCount), 64'd0);
      check("rst_hostBusyValid", 64'({hostReadBusy, hostReadValid}), 64'd0);
      tick();
      reset = 1'b0;

      wait_clear(1'b0, n);
      check("init_clear_writes", 64'(n), 64'd1024);
      check_mem_zero("init_mem_zero");

      // single event on bin 5
      send_events(10'd5, 1);
      host_read(10'd5, d, lat, low);
      check("bin5", 64'(d), 64'd1);
      check("bin5_latency", 64'(lat), 64'd3);
      check("count_after_bin5", 64'(eventCount), 64'd1);

      // back-to-back on one bin, then interleaved
      send_events(10'd3, 8);
      send_events(10'd3, 1);
      send_events(10'd4, 1);
      send_events(10'd3, 1);
      host_read(10'd3, d, lat, low);
      check("bin3", 64'(d), 64'd10);
      host_read(10'd4, d, lat, low);
      check("bin4", 64'(d), 64'd1);
      check("count_after_bin34", 64'(eventCount), 64'd12);

      // saturation
      pre_we   = 1'b1;
      pre_addr = 10'd7;
      pre_data = 16'hFFFE;
      tick();
      pre_we = 1'b0;
      check("ovf_before_sat", 64'(overflowSeen), 64'd0);
      send_events(10'd7, 3);
      tick();
      tick();
      check("ovf_after_sat", 64'(overflowSeen), 64'(m_ovf));
      check("ovf_literal", 64'(overflowSeen), 64'd1);
      host_read(10'd7, d, lat, low);
      check("bin7", 64'(d), 64'hFFFF);
      check("count_after_bin7", 64'(eventCount), 64'd15);

      // host read while events saturate port A
      eventValid = 1'b1;
      eventBin   = 10'd9;
      host_read(10'd2, d, lat, low);
      check("bin2_starved", 64'(d), 64'd0);
      check("starve_latency", 64'(lat), 64'(SL + 3));
      check("ready_low_cycles", 64'(low), 64'd1);

      // clear while events are still flowing
      clearStart = 1'b1;
      tick();
      clearStart = 1'b0;
      eventValid = 1'b0;
      wait_clear(1'b1, n);
      check("clear_writes", 64'(n), 64'd1024);
      check("ovf_after_clear", 64'(overflowSeen), 64'd0);
      check("count_after_clear", 64'(eventCount), 64'd0);
      check_mem_zero("mem_zero_after_clear");
      host_read(10'd9, d, lat, low);
      check("bin9_after_clear", 64'(d), 64'd0);

      // reset in the middle of a sweep
      send_events(10'd300, 2);
      clearStart = 1'b1;
      tick();
      clearStart = 1'b0;
      reached = 1'b0;
      for (int i = 0; i < 1200 && !reached; i++) begin
         @(negedge clk);
         if (clearBusy && memWeB && memAddrB == 10'd300) reached = 1'b1;
      end
      check("reached_bin300", 64'(reached), 64'd1);
      reset = 1'b1;
      #1;
      check("midrst_clearBusy", 64'(clearBusy), 64'd0);
      check("midrst_memWeB", 64'(memWeB), 64'd0);
      check("midrst_memAddrB", 64'(memAddrB), 64'd0);
      check("midrst_eventReady", 64'(eventReady), 64'd0);
      check("midrst_eventCount", 64'(eventCount), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      wait_clear(1'b0, n);
      check("restart_clear_writes", 64'(n), 64'd1024);
      check_mem_zero("mem_zero_after_restart");
      host_read(10'd300, d, lat, low);
      check("bin300_after_restart", 64'(d), 64'd0);

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule
